// File: rtl/counter_slot_arbiter.sv
// Round-robin owner of a shared up-counter: grants one requester a timed slot of
// Dur+1 counting cycles, then pulses Done to that requester for one cycle.
//
// state | meaning
// IDLE  | no owner; round-robin pick from ptr among active requests
// RUN   | owner holds the counter; Count steps 0..dur_l unless Req[owner] drops
// DONE  | one-cycle Done pulse to the owner, Grant still held
module counter_slot_arbiter #(
   parameter int N = 4,
   parameter int W = 4
) (
   input  logic           Clk,
   input  logic           Reset,
   input  logic [N-1:0]   Req,
   input  logic [N*W-1:0] Dur,
   output logic [N-1:0]   Grant,
   output logic           Busy,
   output logic [N-1:0]   Done,
   output logic [W-1:0]   Count
);

   localparam int PW = (N > 2) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state;
   logic [PW-1:0] ptr;
   logic [PW-1:0] owner;
   logic [W-1:0]  dur_l;

   logic          win_found;
   logic [PW-1:0] win_idx;
   int            j;

   // Search starts at ptr and wraps, so the most recently served requester goes last.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      j         = 0;
      for (int k = 0; k < N; k++) begin
         j = int'(ptr) + k;
         if (j >= N) j = j - N;
         if (!win_found && Req[j]) begin
            win_found = 1'b1;
            win_idx   = PW'(j);
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state <= IDLE;
         Grant <= '0;
         Done  <= '0;
         Count <= '0;
         Busy  <= 1'b0;
         dur_l <= '0;
         ptr   <= '0;
         owner <= '0;
      end else begin
         case (state)
            IDLE: begin
               Done <= '0;
               if (win_found) begin
                  Grant <= {{(N-1){1'b0}}, 1'b1} << win_idx;
                  dur_l <= Dur[win_idx*W +: W];
                  Count <= '0;
                  Busy  <= 1'b1;
                  owner <= win_idx;
                  ptr   <= (win_idx == PW'(N-1)) ? '0 : win_idx + 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               // An abandoned request wins over a slot that is just completing.
               if (!Req[owner]) begin
                  Grant <= '0;
                  Count <= '0;
                  Busy  <= 1'b0;
                  state <= IDLE;
               end else if (Count == dur_l) begin
                  Count <= '0;
                  Done  <= Grant;
                  state <= DONE;
               end else begin
                  Count <= Count + 1'b1;
               end
            end
            DONE: begin
               Grant <= '0;
               Done  <= '0;
               Busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               Grant <= '0;
               Done  <= '0;
               Count <= '0;
               Busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_counter_slot_arbiter.sv
// Self-checking bench for counter_slot_arbiter: a vector table for single-slot and
// round-robin behaviour, then hand-written fairness, abort, max-duration and reset sequences.
module tb_counter_slot_arbiter;

   logic        Clk;
   logic        Reset;
   logic [3:0]  Req;
   logic [15:0] Dur;
   logic [3:0]  Grant;
   logic        Busy;
   logic [3:0]  Done;
   logic [3:0]  Count;

   counter_slot_arbiter #(.N(4), .W(4)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .Req   (Req),
      .Dur   (Dur),
      .Grant (Grant),
      .Busy  (Busy),
      .Done  (Done),
      .Count (Count)
   );

   typedef struct {
      string       nm;
      logic        rst;
      logic [3:0]  req;
      logic [15:0] dur;
      logic [3:0]  g;
      logic [3:0]  d;
      logic        b;
      logic [3:0]  c;
   } vec_t;

   vec_t tbl[$];
   vec_t sb[$];
   int   total = 0;
   int   bad   = 0;

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   function automatic logic [15:0] mk_dur(input logic [3:0] d0, input logic [3:0] d1,
                                          input logic [3:0] d2, input logic [3:0] d3);
      return {d3, d2, d1, d0};
   endfunction

   function automatic vec_t v(input string nm, input logic rst, input logic [3:0] req,
                              input logic [15:0] dur, input logic [3:0] g, input logic [3:0] d,
                              input logic b, input logic [3:0] c);
      vec_t r;
      r.nm = nm; r.rst = rst; r.req = req; r.dur = dur;
      r.g = g; r.d = d; r.b = b; r.c = c;
      return r;
   endfunction

   // Drive one cycle of inputs, queue what the outputs must be after the edge, then check.
   task automatic step(input vec_t x);
      vec_t e;
      @(negedge Clk);
      Reset = x.rst;
      Req   = x.req;
      Dur   = x.dur;
      sb.push_back(x);
      @(posedge Clk);
      #1;
      e = sb.pop_front();
      total++;
      if ({Grant, Done, Busy, Count} !== {e.g, e.d, e.b, e.c}) begin
         bad++;
         $display("FAIL %s: got grant=%b done=%b busy=%b count=%0d, want grant=%b done=%b busy=%b count=%0d",
                  e.nm, Grant, Done, Busy, Count, e.g, e.d, e.b, e.c);
      end
   endtask

   task automatic s(input string nm, input logic rst, input logic [3:0] req,
                    input logic [15:0] dur, input logic [3:0] g, input logic [3:0] d,
                    input logic b, input logic [3:0] c);
      step(v(nm, rst, req, dur, g, d, b, c));
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation time limit reached, want completion");
      $fatal(1, "timeout");
   end

   initial begin
      logic [15:0] d3;
      logic [15:0] d0;
      logic [15:0] d10;
      Reset = 1'b1;
      Req   = '0;
      Dur   = '0;
      d3  = mk_dur(4'd3, 4'd0, 4'd0, 4'd0);
      d0  = mk_dur(4'd0, 4'd0, 4'd0, 4'd0);
      d10 = mk_dur(4'd10, 4'd0, 4'd0, 4'd0);

      // Single request with Dur0 = 3.
      tbl.push_back(v("reset",      1, 4'b0000, d3, 4'b0000, 4'b0000, 0, 4'd0));
      tbl.push_back(v("single_g",   0, 4'b0001, d3, 4'b0001, 4'b0000, 1, 4'd0));
      tbl.push_back(v("single_c1",  0, 4'b0001, d3, 4'b0001, 4'b0000, 1, 4'd1));
      tbl.push_back(v("single_c2",  0, 4'b0001, d3, 4'b0001, 4'b0000, 1, 4'd2));
      tbl.push_back(v("single_c3",  0, 4'b0001, d3, 4'b0001, 4'b0000, 1, 4'd3));
      tbl.push_back(v("single_done",0, 4'b0001, d3, 4'b0001, 4'b0001, 1, 4'd0));
      tbl.push_back(v("single_rel", 0, 4'b0000, d3, 4'b0000, 4'b0000, 0, 4'd0));
      tbl.push_back(v("single_idle",0, 4'b0000, d3, 4'b0000, 4'b0000, 0, 4'd0));
      // Round-robin with all requests held and Dur = 0.
      tbl.push_back(v("rr_reset",   1, 4'b0000, d0, 4'b0000, 4'b0000, 0, 4'd0));
      tbl.push_back(v("rr_g0",      0, 4'b1111, d0, 4'b0001, 4'b0000, 1, 4'd0));
      tbl.push_back(v("rr_d0",      0, 4'b1111, d0, 4'b0001, 4'b0001, 1, 4'd0));
      tbl.push_back(v("rr_gap0",    0, 4'b1111, d0, 4'b0000, 4'b0000, 0, 4'd0));
      tbl.push_back(v("rr_g1",      0, 4'b1111, d0, 4'b0010, 4'b0000, 1, 4'd0));
      tbl.push_back(v("rr_d1",      0, 4'b1111, d0, 4'b0010, 4'b0010, 1, 4'd0));
      tbl.push_back(v("rr_gap1",    0, 4'b1111, d0, 4'b0000, 4'b0000, 0, 4'd0));
      tbl.push_back(v("rr_g2",      0, 4'b1111, d0, 4'b0100, 4'b0000, 1, 4'd0));
      tbl.push_back(v("rr_d2",      0, 4'b1111, d0, 4'b0100, 4'b0100, 1, 4'd0));
      tbl.push_back(v("rr_gap2",    0, 4'b1111, d0, 4'b0000, 4'b0000, 0, 4'd0));
      tbl.push_back(v("rr_g3",      0, 4'b1111, d0, 4'b1000, 4'b0000, 1, 4'd0));
      tbl.push_back(v("rr_d3",      0, 4'b1111, d0, 4'b1000, 4'b1000, 1, 4'd0));
      tbl.push_back(v("rr_gap3",    0, 4'b1111, d0, 4'b0000, 4'b0000, 0, 4'd0));
      tbl.push_back(v("rr_wrap_g0", 0, 4'b1111, d0, 4'b0001, 4'b0000, 1, 4'd0));
      tbl.push_back(v("rr_wrap_d0", 0, 4'b1111, d0, 4'b0001, 4'b0001, 1, 4'd0));
      tbl.push_back(v("rr_end",     0, 4'b0000, d0, 4'b0000, 4'b0000, 0, 4'd0));

      for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

      // Fairness: after serving requester 2, ptr = 3 so 0101 must pick requester 0.
      s("fair_reset", 1, 4'b0000, d0, 4'b0000, 4'b0000, 0, 4'd0);
      s("fair_g2",    0, 4'b0100, d0, 4'b0100, 4'b0000, 1, 4'd0);
      s("fair_d2",    0, 4'b0100, d0, 4'b0100, 4'b0100, 1, 4'd0);
      s("fair_gap",   0, 4'b0101, d0, 4'b0000, 4'b0000, 0, 4'd0);
      s("fair_g0",    0, 4'b0101, d0, 4'b0001, 4'b0000, 1, 4'd0);
      s("fair_d0",    0, 4'b0101, d0, 4'b0001, 4'b0001, 1, 4'd0);
      s("fair_end",   0, 4'b0000, d0, 4'b0000, 4'b0000, 0, 4'd0);

      // Abort: requester 0 drops at Count = 4; pending requester 1 follows.
      s("abort_reset", 1, 4'b0000, d10, 4'b0000, 4'b0000, 0, 4'd0);
      s("abort_g0",    0, 4'b0011, d10, 4'b0001, 4'b0000, 1, 4'd0);
      for (int i = 1; i <= 4; i++)
         s("abort_count", 0, 4'b0011, d10, 4'b0001, 4'b0000, 1, 4'(i));
      s("abort_drop",  0, 4'b0010, d10, 4'b0000, 4'b0000, 0, 4'd0);
      s("abort_g1",    0, 4'b0010, d10, 4'b0010, 4'b0000, 1, 4'd0);
      s("abort_d1",    0, 4'b0010, d10, 4'b0010, 4'b0010, 1, 4'd0);
      s("abort_end",   0, 4'b0000, d10, 4'b0000, 4'b0000, 0, 4'd0);

      // Max duration on requester 2 (ptr = 2 now); Dur changed mid-slot must be ignored.
      s("max_g2", 0, 4'b0100, mk_dur(4'd0, 4'd0, 4'd15, 4'd0), 4'b0100, 4'b0000, 1, 4'd0);
      for (int i = 1; i <= 15; i++)
         s("max_count", 0, 4'b0100, mk_dur(4'd0, 4'd0, (i < 5) ? 4'd15 : 4'd3, 4'd0),
           4'b0100, 4'b0000, 1, 4'(i));
      s("max_done", 0, 4'b0100, mk_dur(4'd0, 4'd0, 4'd3, 4'd0), 4'b0100, 4'b0100, 1, 4'd0);
      s("max_end",  0, 4'b0000, d0, 4'b0000, 4'b0000, 0, 4'd0);

      // Reset mid-RUN at Count = 2; ptr = 3 picks requester 3 first, ptr = 0 after reset.
      s("rst_g3",   0, 4'b1010, mk_dur(4'd5, 4'd5, 4'd5, 4'd5), 4'b1000, 4'b0000, 1, 4'd0);
      s("rst_c1",   0, 4'b1010, mk_dur(4'd5, 4'd5, 4'd5, 4'd5), 4'b1000, 4'b0000, 1, 4'd1);
      s("rst_c2",   0, 4'b1010, mk_dur(4'd5, 4'd5, 4'd5, 4'd5), 4'b1000, 4'b0000, 1, 4'd2);
      s("rst_mid",  1, 4'b1010, mk_dur(4'd5, 4'd5, 4'd5, 4'd5), 4'b0000, 4'b0000, 0, 4'd0);
      s("rst_g1",   0, 4'b1010, mk_dur(4'd5, 4'd5, 4'd5, 4'd5), 4'b0010, 4'b0000, 1, 4'd0);
      s("rst_g1c1", 0, 4'b1010, mk_dur(4'd5, 4'd5, 4'd5, 4'd5), 4'b0010, 4'b0000, 1, 4'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
